multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle control sequencer for the RV32I datapath. Replaces single-cycle combinational decode with a state machine that fetches an instruction over a request/acknowledge handshake, decodes its `instr_type`, and sequences the datapath control signals across EXEC, MEM and WB phases. It supports variable-latency instruction and data memory, a data-memory timeout with a sticky error, and a retired-instruction counter. It sits between the fetch/memory interfaces and the datapath, and drives the same control set (`resultsrc`, `memwrite`, `alusrc`, `immsrc`, `op`, `regwrite`).

## Interface
Parameters:
- `OP_W`, 2, width of the ALU op code `op`.
- `MEM_TIMEOUT`, 16, number of MEM cycles without `dmem_ack` before the error trap (≥1).
- `CNT_W`, 32, width of `instret`.

Ports:
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `arst`  in  1  reset, asynchronous, active-high.
- `run`  in  1  start/continue enable, sampled in IDLE.
- `imem_req`  out  1  instruction fetch request.
- `imem_ack`  in  1  fetch complete; `instr_type` is valid in the same cycle.
- `instr_type`  in  `rv32i_pkg::instr_type_t`  decoded class: R_TYPE, I_TYPE_LOAD, I_TYPE_ALU; any other value is treated as store.
- `dmem_req`  out  1  data memory request.
- `dmem_ack`  in  1  data access complete.
- `resultsrc`  out  1  1 selects load data for writeback.
- `memwrite`  out  1  store strobe.
- `alusrc`  out  1  1 selects the immediate operand.
- `immsrc`  out  1  1 selects the S-type immediate.
- `op`  out  `OP_W`  ALU op class: 0 R, 1 load/store, 2 I-ALU (zero-extended).
- `regwrite`  out  1  register file write enable.
- `pc_en`  out  1  one-cycle pulse when an instruction retires.
- `err`  out  1  sticky data-memory timeout flag.
- `err_clr`  in  1  clears ERR and returns the FSM to IDLE.
- `instret`  out  `CNT_W`  retired-instruction count.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, ERR.
- Reset:
  - State goes to IDLE.
  - Every output is 0, including `instret` and `err`.
- IDLE: go to FETCH when `run`=1; otherwise stay.
- FETCH:
  - `imem_req`=1.
  - On `imem_ack`, latch `instr_type` into an internal register and go to DECODE.
  - Wait indefinitely if no ack arrives; there is no fetch timeout.
- DECODE:
  - Register `alusrc`, `immsrc` and `op` from the latched type:
    - R: alusrc 0, immsrc 0, op 0.
    - LOAD: alusrc 1, immsrc 0, op 1.
    - ALU: alusrc 1, immsrc 0, op 2.
    - store: alusrc 1, immsrc 1, op 1.
  - These values hold from the cycle after DECODE until the next DECODE.
  - Go to EXEC.
- EXEC: go to WB for R and ALU; go to MEM for LOAD and store.
- MEM:
  - `dmem_req`=1; `memwrite`=1 for store only.
  - A timeout counter counts MEM cycles.
  - On `dmem_ack`: LOAD goes to WB. Store pulses `pc_en`, increments `instret`, and goes to FETCH if `run`=1, else IDLE.
  - If `dmem_ack` is still low in MEM cycle number `MEM_TIMEOUT`, go to ERR.
  - `dmem_ack` in the timeout cycle wins: the access completes normally.
- WB:
  - `regwrite`=1; `resultsrc`=1 for LOAD, 0 otherwise.
  - Pulse `pc_en` and increment `instret`.
  - Go to FETCH if `run`=1, else IDLE.
- ERR:
  - `err`=1; `imem_req`, `dmem_req`, `memwrite`, `regwrite` and `pc_en` are 0.
  - On `err_clr`=1, clear `err` and go to IDLE.
  - `err_clr` is ignored in every other state.
- `instret` wraps modulo 2^CNT_W with no saturation.
- `regwrite`, `memwrite`, `dmem_req`, `imem_req` and `pc_en` are decoded from the current state and are never asserted outside the states listed above.

## Timing
- Latency counts from the first FETCH cycle, with each ack arriving in the first cycle of its request:
  - R and I-ALU: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load: 5 cycles.
  - Store: 4 cycles.
- Each extra cycle of ack delay adds exactly one cycle.
- Back-to-back execution with `run` held high: the FETCH of the next instruction is the cycle after WB (or after the store's MEM ack).
- The timeout trap is entered on the cycle after MEM cycle `MEM_TIMEOUT`.
- `err` rises in that first ERR cycle.
- `arst` mid-operation: all outputs go to 0 immediately, without waiting for a clock edge. No retirement occurs for the interrupted instruction.

## Test plan
- Reset, `run`=1, R_TYPE with immediate `imem_ack` -> `imem_req` high in cycle 1; `regwrite`=1 and `pc_en`=1 in cycle 4 with `alusrc`=0 and `op`=0; `instret`=1.
- I_TYPE_LOAD with `dmem_ack` delayed 3 cycles -> MEM lasts 3 cycles with `memwrite`=0; WB has `resultsrc`=1 and `regwrite`=1; total 7 cycles.
- Store -> `memwrite`=1 and `immsrc`=1 throughout MEM; `regwrite` is never asserted; `pc_en` pulses in the ack cycle.
- `MEM_TIMEOUT`=4 with no `dmem_ack` -> ERR entered after 4 MEM cycles, `err`=1, and the FSM stays in ERR until `err_clr`, then goes to IDLE with `instret` unchanged.
- `dmem_ack` in exactly MEM cycle `MEM_TIMEOUT` -> normal completion with `err`=0.
- Assert `arst` during MEM -> all outputs 0 asynchronously; after release the FSM is in IDLE; `instret` rolls over to 0 after 2^CNT_W retirements when tested with `CNT_W`=3.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I decode types used between the fetch front end and the control sequencer.
package rv32i_pkg;

    typedef enum logic [1:0] {
        R_TYPE      = 2'd0,
        I_TYPE_LOAD = 2'd1,
        I_TYPE_ALU  = 2'd2,
        S_TYPE      = 2'd3
    } instr_type_t;

endpackage

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer: fetches an instruction over req/ack, then steps
// the datapath controls through EXEC, MEM and WB. It also counts retired instructions.
module multicycle_ctrl
    import rv32i_pkg::*;
#(
    parameter int OP_W        = 2,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             run,
    output logic             imem_req,
    input  logic             imem_ack,
    input  instr_type_t      instr_type,
    output logic             dmem_req,
    input  logic             dmem_ack,
    output logic             resultsrc,
    output logic             memwrite,
    output logic             alusrc,
    output logic             immsrc,
    output logic [OP_W-1:0]  op,
    output logic             regwrite,
    output logic             pc_en,
    output logic             err,
    input  logic             err_clr,
    output logic [CNT_W-1:0] instret,
    output logic [2:0]       dbg_state
);

    // Handshake: a request stays high for as long as the FSM waits in FETCH or MEM.
    // The cycle in which ack is seen high while req is high completes the transfer.
    // Ack has no effect in any other cycle.

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        ERR    = 3'd6
    } state_t;

    localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(MEM_TIMEOUT - 1);

    state_t         state;
    state_t         state_nxt;
    instr_type_t    itype;
    logic [TW-1:0]  mem_cnt;
    logic           is_load;
    logic           is_store;
    logic           is_mem;
    logic           mem_timeout;

    assign is_load     = (itype == I_TYPE_LOAD);
    assign is_store    = (itype != R_TYPE) && (itype != I_TYPE_LOAD) && (itype != I_TYPE_ALU);
    assign is_mem      = is_load || is_store;
    // mem_cnt holds the zero-based index of the current MEM cycle.
    assign mem_timeout = (mem_cnt == TO_LAST);
    assign dbg_state   = state;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (run) state_nxt = FETCH;
            FETCH:   if (imem_ack) state_nxt = DECODE;
            DECODE:  state_nxt = EXEC;
            EXEC:    state_nxt = is_mem ? MEM : WB;
            MEM: begin
                if (dmem_ack) begin
                    if (is_load) state_nxt = WB;
                    else         state_nxt = run ? FETCH : IDLE;
                end else if (mem_timeout) begin
                    state_nxt = ERR;
                end
            end
            WB:      state_nxt = run ? FETCH : IDLE;
            ERR:     if (err_clr) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        memwrite  = 1'b0;
        regwrite  = 1'b0;
        resultsrc = 1'b0;
        pc_en     = 1'b0;
        err       = 1'b0;
        case (state)
            FETCH: imem_req = 1'b1;
            MEM: begin
                dmem_req = 1'b1;
                memwrite = is_store;
                pc_en    = is_store && dmem_ack;
            end
            WB: begin
                regwrite  = 1'b1;
                resultsrc = is_load;
                pc_en     = 1'b1;
            end
            ERR:     err = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            itype   <= R_TYPE;
            alusrc  <= 1'b0;
            immsrc  <= 1'b0;
            op      <= '0;
            mem_cnt <= '0;
            instret <= '0;
        end else begin
            if (state == FETCH && imem_ack) begin
                itype <= instr_type;
            end
            if (state == DECODE) begin
                case (itype)
                    R_TYPE: begin
                        alusrc <= 1'b0;
                        immsrc <= 1'b0;
                        op     <= OP_W'(0);
                    end
                    I_TYPE_LOAD: begin
                        alusrc <= 1'b1;
                        immsrc <= 1'b0;
                        op     <= OP_W'(1);
                    end
                    I_TYPE_ALU: begin
                        alusrc <= 1'b1;
                        immsrc <= 1'b0;
                        op     <= OP_W'(2);
                    end
                    default: begin
                        alusrc <= 1'b1;
                        immsrc <= 1'b1;
                        op     <= OP_W'(1);
                    end
                endcase
            end
            if (state == MEM) begin
                mem_cnt <= mem_cnt + TW'(1);
            end else begin
                mem_cnt <= '0;
            end
            if (pc_en) begin
                instret <= instret + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl with a short MEM timeout and a 3-bit retire counter.
module tb_multicycle_ctrl;
    import rv32i_pkg::*;

    localparam int OP_W        = 2;
    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 3;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_ERR    = 3'd6;

    logic             clk;
    logic             arst;
    logic             run;
    logic             imem_req;
    logic             imem_ack;
    instr_type_t      instr_type;
    logic             dmem_req;
    logic             dmem_ack;
    logic             resultsrc;
    logic             memwrite;
    logic             alusrc;
    logic             immsrc;
    logic [OP_W-1:0]  op;
    logic             regwrite;
    logic             pc_en;
    logic             err;
    logic             err_clr;
    logic [CNT_W-1:0] instret;
    logic [2:0]       dbg_state;

    int total   = 0;
    int bad     = 0;
    int exp_ret = 0;

    multicycle_ctrl #(
        .OP_W        (OP_W),
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk        (clk),
        .arst       (arst),
        .run        (run),
        .imem_req   (imem_req),
        .imem_ack   (imem_ack),
        .instr_type (instr_type),
        .dmem_req   (dmem_req),
        .dmem_ack   (dmem_ack),
        .resultsrc  (resultsrc),
        .memwrite   (memwrite),
        .alusrc     (alusrc),
        .immsrc     (immsrc),
        .op         (op),
        .regwrite   (regwrite),
        .pc_en      (pc_en),
        .err        (err),
        .err_clr    (err_clr),
        .instret    (instret),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // every output packed together; all must read 0 in reset
    function automatic logic [31:0] all_out();
        return {14'd0, instret, imem_req, dmem_req, resultsrc, memwrite, alusrc,
                immsrc, op, regwrite, pc_en, err, dbg_state};
    endfunction

    // Runs one instruction starting in its first FETCH cycle. iw/dw are the number of
    // cycles ack is held off; nrun is the run level seen at retirement.
    task automatic do_instr(input instr_type_t t, input int iw, input int dw,
                            input int exp_cyc, input logic nrun);
        logic       e_alu, e_imm, e_load, e_store;
        logic [1:0] e_op;
        int         cyc;
        cyc = 0;
        case (t)
            R_TYPE:      begin e_alu = 0; e_imm = 0; e_op = 2'd0; end
            I_TYPE_LOAD: begin e_alu = 1; e_imm = 0; e_op = 2'd1; end
            I_TYPE_ALU:  begin e_alu = 1; e_imm = 0; e_op = 2'd2; end
            default:     begin e_alu = 1; e_imm = 1; e_op = 2'd1; end
        endcase
        e_load  = (t == I_TYPE_LOAD);
        e_store = (t == S_TYPE);
        for (int k = 0; k <= iw; k++) begin
            imem_ack   = (k == iw);
            instr_type = (k == iw) ? t : ((t == S_TYPE) ? R_TYPE : S_TYPE);
            settle();
            check("fetch_state", dbg_state, S_FETCH);
            check("fetch_req", imem_req, 1);
            tick(); cyc++;
        end
        imem_ack = 1'b0;
        settle();
        check("decode_state", dbg_state, S_DECODE);
        check("decode_req", imem_req, 0);
        tick(); cyc++;
        settle();
        check("exec_state", dbg_state, S_EXEC);
        check("exec_alusrc", alusrc, e_alu);
        check("exec_immsrc", immsrc, e_imm);
        check("exec_op", op, e_op);
        check("exec_regwrite", regwrite, 0);
        tick(); cyc++;
        if (e_load || e_store) begin
            for (int k = 0; k <= dw; k++) begin
                dmem_ack = (k == dw);
                if (e_store && k == dw) run = nrun;
                settle();
                check("mem_state", dbg_state, S_MEM);
                check("mem_req", dmem_req, 1);
                check("mem_memwrite", memwrite, e_store);
                check("mem_immsrc", immsrc, e_imm);
                check("mem_pc_en", pc_en, e_store && (k == dw));
                check("mem_regwrite", regwrite, 0);
                check("mem_err", err, 0);
                tick(); cyc++;
            end
            dmem_ack = 1'b0;
        end
        if (!e_store) begin
            run = nrun;
            settle();
            check("wb_state", dbg_state, S_WB);
            check("wb_regwrite", regwrite, 1);
            check("wb_resultsrc", resultsrc, e_load);
            check("wb_pc_en", pc_en, 1);
            check("wb_dmem_req", dmem_req, 0);
            tick(); cyc++;
        end
        exp_ret = (exp_ret + 1) % 8;
        settle();
        check("latency", cyc, exp_cyc);
        check("instret", instret, exp_ret);
        check("after_state", dbg_state, nrun ? S_FETCH : S_IDLE);
        check("after_pc_en", pc_en, 0);
    endtask

    initial begin
        arst = 1'b1; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        err_clr = 1'b0; instr_type = R_TYPE;
        #12;
        settle();
        check("reset_outputs", all_out(), 0);
        arst = 1'b0;
        tick();
        settle();
        check("idle_hold", dbg_state, S_IDLE);
        tick();
        settle();
        check("idle_hold2", dbg_state, S_IDLE);

        // R, then back-to-back load (3-cycle MEM), store, slow-fetch ALU, R
        run = 1'b1; tick();
        do_instr(R_TYPE, 0, 0, 4, 1'b0);
        run = 1'b1; tick();
        do_instr(I_TYPE_LOAD, 0, 2, 7, 1'b1);
        do_instr(S_TYPE, 0, 0, 4, 1'b1);
        do_instr(I_TYPE_ALU, 2, 0, 6, 1'b1);
        do_instr(R_TYPE, 0, 0, 4, 1'b1);
        // ack lands in the last allowed MEM cycle
        do_instr(I_TYPE_LOAD, 1, 3, 9, 1'b1);
        do_instr(S_TYPE, 0, 3, 7, 1'b0);

        // timeout trap
        run = 1'b1; tick();
        imem_ack = 1'b1; instr_type = I_TYPE_LOAD;
        tick();
        imem_ack = 1'b0;
        tick();
        tick();
        for (int k = 0; k < MEM_TIMEOUT; k++) begin
            settle();
            check("to_mem_state", dbg_state, S_MEM);
            check("to_mem_err", err, 0);
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            settle();
            check("err_state", dbg_state, S_ERR);
            check("err_flag", err, 1);
            check("err_quiet", {imem_req, dmem_req, memwrite, regwrite, pc_en}, 0);
            tick();
        end
        err_clr = 1'b1; run = 1'b0;
        tick();
        err_clr = 1'b0;
        settle();
        check("err_clr_state", dbg_state, S_IDLE);
        check("err_clr_flag", err, 0);
        check("err_instret", instret, 7);

        // eighth retirement wraps the 3-bit counter
        run = 1'b1; tick();
        do_instr(R_TYPE, 0, 0, 4, 1'b0);
        check("rollover", instret, 0);

        // async reset while a store waits in MEM
        run = 1'b1; tick();
        imem_ack = 1'b1; instr_type = S_TYPE;
        tick();
        imem_ack = 1'b0;
        tick();
        tick();
        settle();
        check("pre_rst_memwrite", memwrite, 1);
        check("pre_rst_immsrc", immsrc, 1);
        tick();
        arst = 1'b1; run = 1'b0;
        #1;
        check("async_rst_outputs", all_out(), 0);
        #2;
        arst = 1'b0;
        exp_ret = 0;
        tick();
        settle();
        check("post_rst_state", dbg_state, S_IDLE);
        check("post_rst_instret", instret, exp_ret);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
